// File: rtl/desc_rb_sched_pkg.sv
// Shared types for the descriptor-ring read scheduler: FSM encoding, queue id type,
// and the round-robin base helper.
package desc_rb_sched_pkg;

    typedef enum logic {
        SCHED_IDLE  = 1'b0,
        SCHED_SERVE = 1'b1
    } sched_state_e;

    localparam int NB_QUEUES_DFLT = 4;

    typedef logic [$clog2(NB_QUEUES_DFLT)-1:0] qid_t;

    function automatic int wrap_inc(input int q, input int n);
        return (q == n - 1) ? 0 : q + 1;
    endfunction

endpackage

// File: rtl/desc_rb_sched_rr_pick.sv
// Rotate-priority first-set finder: returns the first set request at or after base,
// wrapping modulo N.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] base,
    output logic                 found,
    output logic [$clog2(N)-1:0] idx
);

    always_comb begin
        int c;
        c     = 0;
        found = 1'b0;
        idx   = '0;
        // Walk from the farthest offset down so the nearest hit is the last write.
        for (int i = N - 1; i >= 0; i--) begin
            c = (int'(base) + i) % N;
            if (req[c]) begin
                found = 1'b1;
                idx   = $clog2(N)'(c);
            end
        end
    end

endmodule

// File: rtl/desc_rb_sched.sv
// Round-robin read scheduler over a bank of descriptor rings; pops at most one ring
// per cycle and forwards the entry, tagged with its queue id, on a valid/ready stream.
module desc_rb_sched
    import desc_rb_sched_pkg::*;
#(
    parameter int NB_QUEUES = NB_QUEUES_DFLT,
    parameter int DWIDTH    = 64,
    parameter int AWIDTH    = 9,
    parameter int QUANTUM   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NB_QUEUES*AWIDTH-1:0]   rb_occup,
    input  logic [NB_QUEUES*DWIDTH-1:0]   rb_rd_data,
    output logic [NB_QUEUES-1:0]          rb_rd_en,
    input  logic [NB_QUEUES-1:0]          q_enable,
    output logic [DWIDTH-1:0]             out_data,
    output logic [$clog2(NB_QUEUES)-1:0]  out_qid,
    output logic                          out_valid,
    input  logic                          out_ready
);

    localparam int QW = $clog2(NB_QUEUES);
    localparam int CW = $clog2(QUANTUM + 1);
    localparam logic [CW-1:0] CREDIT_FULL = CW'(QUANTUM);

    logic [NB_QUEUES-1:0][AWIDTH-1:0] occup_r;
    logic [NB_QUEUES-1:0][DWIDTH-1:0] rd_data_q;
    logic [NB_QUEUES-1:0]             nonempty;

    sched_state_e  state, state_nxt;
    logic [QW-1:0] cur_q, cur_q_nxt, pick_base, pick_idx;
    logic [CW-1:0] credit, credit_nxt;
    logic          pick_found, cur_ok, pop;

    assign rd_data_q = rb_rd_data;

    // Decisions only ever look at registered occupancy, so rd_en never feeds back
    // combinationally through the ring's netted-out occup.
    for (genvar q = 0; q < NB_QUEUES; q++) begin : g_ne
        assign nonempty[q] = occup_r[q] != '0;
    end

    assign pick_base = QW'(wrap_inc(int'(cur_q), NB_QUEUES));
    assign cur_ok    = q_enable[cur_q] && nonempty[cur_q];

    rr_pick #(.N(NB_QUEUES)) u_pick (
        .req   (q_enable & nonempty),
        .base  (pick_base),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_nxt  = state;
        cur_q_nxt  = cur_q;
        credit_nxt = credit;
        pop        = 1'b0;
        case (state)
            SCHED_IDLE: begin
                if (pick_found) begin
                    state_nxt  = SCHED_SERVE;
                    cur_q_nxt  = pick_idx;
                    credit_nxt = CREDIT_FULL;
                end
            end
            SCHED_SERVE: begin
                // Pops are held off during reset so no entry leaves a ring only to be dropped.
                pop = cur_ok && (!out_valid || out_ready) && !rst;
                if (pop)
                    credit_nxt = credit - 1'b1;
                if (!cur_ok || (pop && credit == CW'(1)))
                    state_nxt = SCHED_IDLE;
            end
            default: state_nxt = SCHED_IDLE;
        endcase
    end

    assign rb_rd_en = pop ? (NB_QUEUES'(1) << cur_q) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SCHED_IDLE;
            cur_q     <= QW'(NB_QUEUES - 1);
            credit    <= '0;
            occup_r   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_qid   <= '0;
        end else begin
            state   <= state_nxt;
            cur_q   <= cur_q_nxt;
            credit  <= credit_nxt;
            occup_r <= rb_occup;
            if (pop) begin
                out_data  <= rd_data_q[cur_q];
                out_qid   <= cur_q;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_desc_rb_sched.sv
// Directed bench for desc_rb_sched with a behavioural show-ahead ring per queue.
module tb_desc_rb_sched;
    import desc_rb_sched_pkg::*;

    localparam int NQ = 4;
    localparam int DW = 64;
    localparam int AW = 9;

    logic              clk = 1'b0;
    logic              rst;
    logic [NQ*AW-1:0]  rb_occup;
    logic [NQ*DW-1:0]  rb_rd_data;
    logic [NQ-1:0]     rb_rd_en;
    logic [NQ-1:0]     q_enable;
    logic [DW-1:0]     out_data;
    qid_t              out_qid;
    logic              out_valid;
    logic              out_ready;

    int checks = 0;
    int errors = 0;

    // Ring model: write visible next cycle, occup nets out the same-cycle read.
    logic [DW-1:0] mem [NQ][64];
    logic [5:0]    head [NQ] = '{default: '0};
    logic [5:0]    tail [NQ] = '{default: '0};
    int            cnt  [NQ] = '{default: 0};
    logic [NQ-1:0] wr_en = '0;
    logic [DW-1:0] wr_data [NQ] = '{default: '0};

    logic [63:0] exp_d[$];
    int          exp_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int q = 0; q < NQ; q++) begin
            if (rb_rd_en[q]) head[q] <= head[q] + 6'd1;
            if (wr_en[q]) begin
                mem[q][tail[q]] <= wr_data[q];
                tail[q]         <= tail[q] + 6'd1;
            end
            cnt[q] <= cnt[q] + int'(wr_en[q]) - int'(rb_rd_en[q]);
        end
    end

    always_comb begin
        rb_occup   = '0;
        rb_rd_data = '0;
        for (int q = 0; q < NQ; q++) begin
            rb_occup[q*AW +: AW]   = AW'(cnt[q] - int'(rb_rd_en[q]));
            rb_rd_data[q*DW +: DW] = mem[q][head[q]];
        end
    end

    desc_rb_sched #(.NB_QUEUES(NQ), .DWIDTH(DW), .AWIDTH(AW), .QUANTUM(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .rb_occup   (rb_occup),
        .rb_rd_data (rb_rd_data),
        .rb_rd_en   (rb_rd_en),
        .q_enable   (q_enable),
        .out_data   (out_data),
        .out_qid    (out_qid),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        next();
        rst = 1'b1;
        next();
        rst = 1'b0;
    endtask

    task automatic load(input int q, input logic [63:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            next();
            wr_en[q]   = 1'b1;
            wr_data[q] = base + 64'(i);
        end
        next();
        wr_en[q] = 1'b0;
    endtask

    task automatic expect_e(input int q, input logic [63:0] d);
        exp_q.push_back(q);
        exp_d.push_back(d);
    endtask

    // Compare every accepted output against the expected list, within a cycle budget.
    task automatic collect(input int n, input int budget, input bit stop_early,
                           output logic [NQ-1:0] seen);
        int idx;
        idx  = 0;
        seen = '0;
        for (int c = 0; c < budget; c++) begin
            next();
            #1;
            seen = seen | rb_rd_en;
            chk("rd_en_onehot0", 64'($onehot0(rb_rd_en)), 64'd1);
            if (out_valid && out_ready) begin
                if (idx < n) begin
                    chk("out_data", out_data, exp_d[idx]);
                    chk("out_qid", 64'(out_qid), 64'(exp_q[idx]));
                end
                idx++;
                if (stop_early && idx == n) break;
            end
        end
        chk("delivered_count", 64'(idx), 64'(n));
        exp_d.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [NQ-1:0] seen;
        rst       = 1'b1;
        q_enable  = '0;
        out_ready = 1'b1;

        // Reset state
        repeat (3) next();
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_qid", 64'(out_qid), 64'd0);
        chk("rst_rd_en", 64'(rb_rd_en), 64'd0);
        rst      = 1'b0;
        q_enable = 4'hF;

        // Three entries on q0: first output 4 cycles after the first write
        for (int t = 0; t < 8; t++) begin
            next();
            wr_en[0]   = (t < 3);
            wr_data[0] = 64'hA + 64'(t);
            #1;
            chk("t1_rd_en", 64'(rb_rd_en), (t >= 3 && t <= 5) ? 64'd1 : 64'd0);
            chk("t1_valid", 64'(out_valid), (t >= 4 && t <= 6) ? 64'd1 : 64'd0);
            if (t >= 4 && t <= 6) begin
                chk("t1_data", out_data, 64'hA + 64'(t - 4));
                chk("t1_qid", 64'(out_qid), 64'd0);
            end
        end

        // Two loaded queues alternate in quanta of 4
        q_enable = '0;
        do_reset();
        load(0, 64'h200, 10);
        load(1, 64'h210, 10);
        next();
        next();
        q_enable = 4'b0011;
        begin
            int n0, n1;
            int pat [20] = '{0,0,0,0,1,1,1,1,0,0,0,0,1,1,1,1,0,0,1,1};
            n0 = 0;
            n1 = 0;
            for (int i = 0; i < 20; i++) begin
                if (pat[i] == 0) begin expect_e(0, 64'h200 + 64'(n0)); n0++; end
                else             begin expect_e(1, 64'h210 + 64'(n1)); n1++; end
            end
        end
        collect(20, 40, 1'b0, seen);

        // Backpressure mid-burst holds one entry and consumes no credit
        q_enable = '0;
        do_reset();
        load(2, 64'h300, 8);
        next();
        next();
        q_enable = 4'b0100;
        #1;
        chk("bp_k0_rd_en", 64'(rb_rd_en), 64'd0);
        for (int k = 1; k <= 10; k++) begin
            next();
            out_ready = !(k >= 2 && k <= 6);
            #1;
            chk("bp_rd_en", 64'(rb_rd_en), (k == 1 || (k >= 7 && k <= 9)) ? 64'h4 : 64'h0);
            chk("bp_valid", 64'(out_valid), (k >= 2) ? 64'd1 : 64'd0);
            if (k >= 2)
                chk("bp_data", out_data, (k <= 7) ? 64'h300 : 64'h300 + 64'(k - 7));
        end
        for (int i = 4; i < 8; i++) expect_e(2, 64'h300 + 64'(i));
        collect(4, 15, 1'b0, seen);

        // Masked queue is never popped until re-enabled
        q_enable = '0;
        do_reset();
        load(1, 64'h410, 6);
        load(0, 64'h400, 2);
        next();
        next();
        q_enable = 4'b1101;
        expect_e(0, 64'h400);
        expect_e(0, 64'h401);
        collect(2, 15, 1'b0, seen);
        chk("q1_masked_rd", 64'(seen[1]), 64'd0);
        q_enable = 4'hF;
        for (int i = 0; i < 6; i++) expect_e(1, 64'h410 + 64'(i));
        collect(6, 25, 1'b0, seen);

        // Wrap from q3 to q0, then reset mid-burst drops the held entry only
        q_enable = '0;
        do_reset();
        load(3, 64'h530, 6);
        load(0, 64'h500, 6);
        next();
        next();
        q_enable = 4'b1000;
        next();
        q_enable = 4'b1001;
        for (int i = 0; i < 4; i++) expect_e(3, 64'h530 + 64'(i));
        expect_e(0, 64'h500);
        expect_e(0, 64'h501);
        collect(6, 20, 1'b1, seen);
        next();
        rst       = 1'b1;
        out_ready = 1'b0;
        #1;
        chk("rst_mid_rd_en", 64'(rb_rd_en), 64'd0);
        next();
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("rst_mid_valid", 64'(out_valid), 64'd0);
        for (int i = 3; i < 6; i++) expect_e(0, 64'h500 + 64'(i));
        expect_e(3, 64'h534);
        expect_e(3, 64'h535);
        collect(5, 30, 1'b0, seen);

        // Single-entry ring with a write landing in the pop cycle
        q_enable = 4'b0001;
        do_reset();
        next();
        wr_en[0]   = 1'b1;
        wr_data[0] = 64'h600;
        next();
        wr_en[0] = 1'b0;
        next();
        next();
        wr_en[0]   = 1'b1;
        wr_data[0] = 64'h601;
        #1;
        chk("se_pop", 64'(rb_rd_en), 64'd1);
        next();
        wr_en[0] = 1'b0;
        #1;
        chk("se_no_second_pop", 64'(rb_rd_en), 64'd0);
        chk("se_valid", 64'(out_valid), 64'd1);
        chk("se_data", out_data, 64'h600);
        expect_e(0, 64'h601);
        collect(1, 12, 1'b0, seen);
        chk("se_ring_empty", 64'(cnt[0]), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/desc_rb_sched.md
# desc_rb_sched

Round-robin read scheduler for a bank of `prefetch_rb` descriptor rings, one ring per queue. It watches each ring's occupancy and issues at most one `rd_en` per cycle to the selected ring. It forwards the popped entry, tagged with its queue id, on a single valid/ready stream toward the DMA/packet engine. Per-queue fairness is enforced by a burst quantum, and software may mask queues at any time.

## Interface
Parameters:
- NB_QUEUES, 4, number of rings served; ≥2.
- DWIDTH, 64, ring entry width.
- AWIDTH, 9, ring occupancy width (matches ring AWIDTH).
- QUANTUM, 4, max consecutive reads from one queue per grant; ≥1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- rb_occup  in  NB_QUEUES×AWIDTH  per-ring `occup`; already nets out the same-cycle read.
- rb_rd_data  in  NB_QUEUES×DWIDTH  per-ring `rd_data`; valid in the same cycle as `rd_en`.
- rb_rd_en  out  NB_QUEUES  per-ring pop, combinational, one-hot or zero.
- q_enable  in  NB_QUEUES  per-queue enable mask; 0 = never granted.
- out_data  out  DWIDTH  popped entry.
- out_qid  out  $clog2(NB_QUEUES)  source queue.
- out_valid  out  1  output holds an entry.
- out_ready  in  1  consumer accepts.

## Operation
- Occupancy registered each cycle: `occup_r[q] <= rb_occup[q]`. All decisions use `occup_r`, which breaks the rd_en→occup loop.
  - `occup_r` never overstates the ring: the read is already netted out and writes only add. It may understate by one cycle.
- State machine:
  - IDLE
    - Pick the first q with `q_enable[q] && occup_r[q]>0`, scanning cur_q+1, cur_q+2, … modulo NB_QUEUES.
    - If found: cur_q<=q, credit<=QUANTUM, go SERVE.
    - Otherwise stay in IDLE.
  - SERVE
    - can_pop = `q_enable[cur_q] && occup_r[cur_q]>0 && (!out_valid || out_ready)`.
    - `rb_rd_en[cur_q]` = can_pop; all other bits 0.
    - On pop: out_data<=rb_rd_data[cur_q], out_qid<=cur_q, out_valid<=1, credit<=credit-1.
    - Go to IDLE if (pop && credit==1), or `occup_r[cur_q]==0`, or `!q_enable[cur_q]`.
    - Output backpressure alone never leaves SERVE and never consumes credit.
- Output register: out_valid clears on `out_ready && !pop`. Simultaneous accept and pop replaces the entry, out_valid stays 1.
- Wrap-around: cur_q=NB_QUEUES-1 scans from 0. Ring pointer wrap is internal to the ring and invisible here.
- Single-entry ring: pop at occup_r=1. Next cycle occup_r=0 (unless a write is in flight), so go to IDLE without a second pop.
- q_enable falling mid-burst: no pop that cycle, go to IDLE. Entries remain in the ring.

## Timing
- Reset values: rb_rd_en=0, out_valid=0, out_data=0, out_qid=0, state=IDLE, cur_q=NB_QUEUES-1, credit=0, occup_r=0.
- Reset mid-operation: any held out_data is dropped; ring contents untouched.
- Ring write → earliest out_valid: write at cycle T, ring occup visible T+1, occup_r T+2, IDLE grant T+2, SERVE pop T+3, out_valid T+4.
- IDLE→SERVE costs one bubble cycle per grant.
- Sustained throughput: 1 entry/cycle within a burst with out_ready=1. Peak across queues is QUANTUM/(QUANTUM+1).
- No combinational path from out_ready to rb_occup consumption other than through rb_rd_en.

## Structure
- Shared struct/constant include holds SCHED_IDLE/SCHED_SERVE state encoding and the `qid_t` width typedef.
- One sub-module: `rr_pick`. It is a combinational, rotate-priority first-set finder over a NB_QUEUES request vector, taking base cur_q+1 and returning found and index.
- Widths: credit is $clog2(QUANTUM+1) bits; occupancy compares are unsigned AWIDTH.

## Test plan
- Reset, q0 loaded with 3 entries (0xA,0xB,0xC), out_ready=1 → out 0xA/0xB/0xC with qid 0 on consecutive cycles starting 4 cycles after the first write; then rb_rd_en=0.
- q0 and q1 each hold 10 entries, QUANTUM=4 → qid sequence 0×4, bubble, 1×4, bubble, 0×4, 1×4, 0×2, 1×2; no reordering within a queue.
- out_ready low for 5 cycles mid-burst → exactly one entry held, no rb_rd_en during the stall, burst resumes with credit unchanged.
- q_enable[1]=0 while q1 holds 6 entries → q1 never popped; set q_enable[1]=1 → all 6 drain in order.
- cur_q=3 with q3 and q0 non-empty → next grant goes to q0 (wrap); reset asserted mid-burst → out_valid=0 next cycle, remaining entries are served after reset from q0.
- Ring with occup=1 and a concurrent write → pop one entry, go to IDLE, re-grant later; every entry delivered exactly once.
